// File: rtl/bitrev_dma_pkg.sv
// bitrev_dma_pkg: shared FSM encodings and buffer-length helper for the bit-reverse DMA
package bitrev_dma_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  function automatic int buf_len(input int fftsiz);
    return 1 << fftsiz;
  endfunction
endpackage

// File: rtl/bit_rev.sv
// bit_rev: combinational reversal of an FFTSIZ-bit index, shared with the core's relative-address path
module bit_rev #(
  parameter int FFTSIZ = 3
) (
  input  logic [FFTSIZ-1:0] idx_i,
  output logic [FFTSIZ-1:0] rev_o
);
  for (genvar g = 0; g < FFTSIZ; g++) begin : g_rev
    assign rev_o[g] = idx_i[FFTSIZ-1-g];
  end
endmodule

// File: rtl/bitrev_dma.sv
// bitrev_dma: copies an N-word buffer, reading in bit-reversed (or linear) order and writing in natural order
module bitrev_dma
  import bitrev_dma_pkg::*;
#(
  parameter int MDATAW = 8,
  parameter int DATAW  = 16,
  parameter int FFTSIZ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rev,
  input  logic [MDATAW-1:0] src_base,
  input  logic [MDATAW-1:0] dst_base,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [MDATAW-1:0] mem_rd_addr,
  input  logic [DATAW-1:0]  mem_rd_data,
  output logic              mem_wr_en,
  output logic [MDATAW-1:0] mem_wr_addr,
  output logic [DATAW-1:0]  mem_wr_data
);
  // one extra index bit so that reaching N is visible even when FFTSIZ == MDATAW
  localparam int IW = FFTSIZ + 1;
  localparam logic [IW-1:0] N    = IW'(buf_len(FFTSIZ));
  localparam logic [IW-1:0] LAST = N - 1'b1;

  logic [1:0]        state_q, state_d;
  logic              rev_q, rev_d;
  logic [MDATAW-1:0] src_q, src_d, dst_q, dst_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic              flag_q, flag_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [MDATAW-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATAW-1:0]  wr_data_q, wr_data_d;
  logic [FFTSIZ-1:0] rev_idx;
  logic [MDATAW-1:0] rd_off;

  bit_rev #(.FFTSIZ(FFTSIZ)) u_bit_rev (
    .idx_i(rd_idx_q[FFTSIZ-1:0]),
    .rev_o(rev_idx)
  );

  assign rd_off = MDATAW'(rev_q ? rev_idx : rd_idx_q[FFTSIZ-1:0]);

  // next state: read issue per FSM state, write pipeline runs one cycle behind returned read data
  always_comb begin
    state_d   = state_q;
    rev_d     = rev_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_idx_d  = rd_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    flag_d    = rd_en_q;
    wr_en_d   = flag_q;
    wr_addr_d = flag_q ? dst_q + MDATAW'(wr_idx_q) : wr_addr_q;
    wr_data_d = flag_q ? mem_rd_data : wr_data_q;
    wr_idx_d  = wr_idx_q + {{FFTSIZ{1'b0}}, flag_q};
    if (state_q == S_IDLE && start) begin
      rev_d     = rev;
      src_d     = src_base;
      dst_d     = dst_base;
      busy_d    = 1'b1;
      state_d   = S_RUN;
      rd_en_d   = ~hold;
      rd_addr_d = src_base;
      rd_idx_d  = {{FFTSIZ{1'b0}}, ~hold};
      wr_idx_d  = '0;
    end else if (state_q == S_RUN && !hold) begin
      rd_en_d   = 1'b1;
      rd_addr_d = src_q + rd_off;
      rd_idx_d  = rd_idx_q + 1'b1;
      state_d   = rd_idx_q == LAST ? S_DRAIN : S_RUN;
    end else if (state_q == S_DRAIN && wr_idx_q == N) begin
      busy_d  = 1'b0;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  // state and registered outputs, cleared asynchronously so an in-flight read is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rev_q     <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rev_q     <= rev_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
      flag_q    <= flag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_bitrev_dma.sv
// tb_bitrev_dma: scoreboard bench for bitrev_dma with N=8 and N=2 instances over mem[a]=a
module tb_bitrev_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, rev = 1'b0, hold = 1'b0;
  logic [7:0]  src_base = '0, dst_base = '0;
  logic        busy, done, mem_rd_en, mem_wr_en;
  logic [7:0]  mem_rd_addr, mem_wr_addr;
  logic [15:0] mem_rd_data = '0, mem_wr_data;
  logic        s_start = 1'b0, s_rev = 1'b0;
  logic [7:0]  s_src = '0, s_dst = '0;
  logic        s_busy, s_done, s_rd_en, s_wr_en;
  logic [7:0]  s_rd_addr, s_wr_addr;
  logic [15:0] s_rd_data = '0, s_wr_data;
  int          n_chk = 0, n_fail = 0;
  time         t0 = 0, t1 = 0;
  logic [7:0]  q_rd[$], q1_rd[$];
  logic [23:0] q_wr[$], q1_wr[$];
  int          q_lat[$], q1_lat[$];
  logic [2:0]  rv3[8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  always #5 clk = ~clk;

  bitrev_dma #(.MDATAW(8), .DATAW(16), .FFTSIZ(3)) dut (
    .clk(clk), .rst(rst), .start(start), .rev(rev), .src_base(src_base), .dst_base(dst_base),
    .hold(hold), .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  bitrev_dma #(.MDATAW(8), .DATAW(16), .FFTSIZ(1)) dut1 (
    .clk(clk), .rst(rst), .start(s_start), .rev(s_rev), .src_base(s_src), .dst_base(s_dst),
    .hold(1'b0), .busy(s_busy), .done(s_done), .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr),
    .mem_rd_data(s_rd_data), .mem_wr_en(s_wr_en), .mem_wr_addr(s_wr_addr), .mem_wr_data(s_wr_data)
  );

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= {8'h00, mem_rd_addr};
    if (s_rd_en) s_rd_data <= {8'h00, s_rd_addr};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd_en) begin
      chk("rd_pending", 32'(q_rd.size() > 0), 1);
      if (q_rd.size() > 0) chk("rd_addr", 32'(mem_rd_addr), 32'(q_rd.pop_front()));
    end
    if (mem_wr_en) begin
      chk("wr_busy", 32'(busy), 1);
      chk("wr_pending", 32'(q_wr.size() > 0), 1);
      if (q_wr.size() > 0) chk("wr_addr_data", 32'({mem_wr_addr, mem_wr_data}), 32'(q_wr.pop_front()));
    end
    if (done) begin
      chk("done_busy", 32'(busy), 0);
      chk("done_pending", 32'(q_lat.size() > 0), 1);
      if (q_lat.size() > 0) chk("done_lat", 32'(($time - t0 - 5) / 10), 32'(q_lat.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (s_rd_en) begin
      chk("n2_rd_pending", 32'(q1_rd.size() > 0), 1);
      if (q1_rd.size() > 0) chk("n2_rd_addr", 32'(s_rd_addr), 32'(q1_rd.pop_front()));
    end
    if (s_wr_en) begin
      chk("n2_wr_pending", 32'(q1_wr.size() > 0), 1);
      if (q1_wr.size() > 0) chk("n2_wr_addr_data", 32'({s_wr_addr, s_wr_data}), 32'(q1_wr.pop_front()));
    end
    if (s_done) begin
      chk("n2_done_busy", 32'(s_busy), 0);
      chk("n2_done_pending", 32'(q1_lat.size() > 0), 1);
      if (q1_lat.size() > 0) chk("n2_done_lat", 32'(($time - t1 - 5) / 10), 32'(q1_lat.pop_front()));
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 0);
    chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 0);
    chk({tag, "_wr_addr"}, 32'(mem_wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(mem_wr_data), 0);
  endtask

  task automatic xfer(input logic r, input logic [7:0] s, input logic [7:0] d, input int hn,
                      input bit poke, input bit abort);
    logic [7:0] a;
    for (int i = 0; i < 8; i++) begin
      a = s + {5'b0, r ? rv3[i] : 3'(i)};
      if (!abort || i < 5) q_rd.push_back(a);
      if (!abort || i < 3) q_wr.push_back({d + 8'(i), 8'h00, a});
    end
    if (!abort) q_lat.push_back(10 + hn);
    @(negedge clk);
    rev = r; src_base = s; dst_base = d; start = 1'b1;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      hold = c < 1 + hn;
      start = poke && c >= 3 && c <= 5;
      if (poke) begin rev = 1'b0; src_base = 8'h80; dst_base = 8'hC0; end
      #1;
      if (abort && c == 4) begin
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        break;
      end
      if (!abort && q_lat.size() == 0) break;
    end
    hold = 1'b0;
    start = 1'b0;
    chk("done_seen", 32'(q_lat.size()), 0);
    chk("rd_left", 32'(q_rd.size()), 0);
    chk("wr_left", 32'(q_wr.size()), 0);
  endtask

  task automatic xfer1(input logic r, input logic [7:0] s, input logic [7:0] d);
    q1_rd.push_back(s);
    q1_rd.push_back(s + 8'd1);
    q1_wr.push_back({d, 8'h00, s});
    q1_wr.push_back({d + 8'd1, 8'h00, s + 8'd1});
    q1_lat.push_back(4);
    @(negedge clk);
    s_rev = r; s_src = s; s_dst = d; s_start = 1'b1;
    @(posedge clk);
    t1 = $time;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 0; c < 20 && q1_lat.size() > 0; c++) begin
      @(negedge clk);
      #1;
    end
    chk("n2_done_seen", 32'(q1_lat.size()), 0);
    chk("n2_rd_left", 32'(q1_rd.size()), 0);
    chk("n2_wr_left", 32'(q1_wr.size()), 0);
  endtask

  initial begin
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer(1'b1, 8'h10, 8'h40, 0, 1'b0, 1'b0);
    xfer(1'b0, 8'hFC, 8'hFE, 0, 1'b0, 1'b0);
    xfer(1'b1, 8'h10, 8'h40, 3, 1'b0, 1'b0);
    xfer(1'b1, 8'h10, 8'h40, 0, 1'b1, 1'b0);
    xfer(1'b0, 8'h20, 8'h60, 0, 1'b0, 1'b0);
    xfer(1'b1, 8'h10, 8'h40, 0, 1'b0, 1'b1);
    xfer(1'b1, 8'h10, 8'h40, 0, 1'b0, 1'b0);
    xfer1(1'b0, 8'h30, 8'h50);
    xfer1(1'b1, 8'hFF, 8'h70);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
